// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side signals of the two-requester memory arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface mem_arbiter_if;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       ack0, ack1, err0, err1;
    logic [7:0] rdata0, rdata1;
    logic       mem_ce, mem_rden, mem_wren;
    logic [7:0] mem_addr, mem_wr_data, mem_rd_data;
    logic       mem_ready, busy, grant_id;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  mem_rd_data, mem_ready,
        output ack0, ack1, err0, err1, rdata0, rdata1,
        output mem_ce, mem_rden, mem_wren, mem_addr, mem_wr_data,
        output busy, grant_id
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output mem_rd_data, mem_ready,
        input  ack0, ack1, err0, err1, rdata0, rdata1,
        input  mem_ce, mem_rden, mem_wren, mem_addr, mem_wr_data,
        input  busy, grant_id
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving two requesters single-access use of one memory,
// with a bounded wait on mem_ready that completes with an error flag.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 8
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [3:0] LAST_WAIT = 4'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last_grant_q, last_grant_d;
    logic       grant_id_q, grant_id_d;
    logic       busy_q, busy_d;
    logic       mem_ce_q, mem_ce_d;
    logic       mem_rden_q, mem_rden_d;
    logic       mem_wren_q, mem_wren_d;
    logic [7:0] mem_addr_q, mem_addr_d;
    logic [7:0] mem_wr_data_q, mem_wr_data_d;
    logic       ack0_q, ack0_d, ack1_q, ack1_d;
    logic       err0_q, err0_d, err1_q, err1_d;
    logic [7:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic       sel_s, sel_we_s, timeout_s;
    logic [7:0] sel_addr_s, sel_wdata_s, done_data_s;

    // With both requesting, the one not served last wins; a lone requester wins outright.
    assign sel_s       = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;
    assign sel_we_s    = sel_s ? bus.we1    : bus.we0;
    assign sel_addr_s  = sel_s ? bus.addr1  : bus.addr0;
    assign sel_wdata_s = sel_s ? bus.wdata1 : bus.wdata0;
    assign timeout_s   = !bus.mem_ready && (cnt_q == LAST_WAIT);
    assign done_data_s = (bus.mem_ready && mem_rden_q) ? bus.mem_rd_data : 8'h00;

    // Next-state and next-output computation for the IDLE/ACCESS/RESP sequence.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_grant_d  = last_grant_q;
        grant_id_d    = grant_id_q;
        busy_d        = busy_q;
        mem_ce_d      = mem_ce_q;
        mem_rden_d    = mem_rden_q;
        mem_wren_d    = mem_wren_q;
        mem_addr_d    = mem_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        err0_d        = 1'b0;
        err1_d        = 1'b0;
        rdata0_d      = 8'h00;
        rdata1_d      = 8'h00;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    grant_id_d    = sel_s;
                    last_grant_d  = sel_s;
                    busy_d        = 1'b1;
                    mem_ce_d      = 1'b1;
                    mem_rden_d    = ~sel_we_s;
                    mem_wren_d    = sel_we_s;
                    mem_addr_d    = sel_addr_s;
                    mem_wr_data_d = sel_wdata_s;
                    cnt_d         = 4'd0;
                    state_d       = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (bus.mem_ready || timeout_s) begin
                    mem_ce_d   = 1'b0;
                    mem_rden_d = 1'b0;
                    mem_wren_d = 1'b0;
                    ack0_d     = ~grant_id_q;
                    ack1_d     = grant_id_q;
                    err0_d     = timeout_s & ~grant_id_q;
                    err1_d     = timeout_s & grant_id_q;
                    rdata0_d   = grant_id_q ? 8'h00 : done_data_s;
                    rdata1_d   = grant_id_q ? done_data_s : 8'h00;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d     = 1'b0;
                mem_ce_d   = 1'b0;
                mem_rden_d = 1'b0;
                mem_wren_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction without an ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            last_grant_q  <= 1'b1;
            grant_id_q    <= 1'b0;
            busy_q        <= 1'b0;
            mem_ce_q      <= 1'b0;
            mem_rden_q    <= 1'b0;
            mem_wren_q    <= 1'b0;
            mem_addr_q    <= 8'h00;
            mem_wr_data_q <= 8'h00;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            err0_q        <= 1'b0;
            err1_q        <= 1'b0;
            rdata0_q      <= 8'h00;
            rdata1_q      <= 8'h00;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_grant_q  <= last_grant_d;
            grant_id_q    <= grant_id_d;
            busy_q        <= busy_d;
            mem_ce_q      <= mem_ce_d;
            mem_rden_q    <= mem_rden_d;
            mem_wren_q    <= mem_wren_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            err0_q        <= err0_d;
            err1_q        <= err1_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
        end
    end

    assign bus.ack0        = ack0_q;
    assign bus.ack1        = ack1_q;
    assign bus.err0        = err0_q;
    assign bus.err1        = err1_q;
    assign bus.rdata0      = rdata0_q;
    assign bus.rdata1      = rdata1_q;
    assign bus.mem_ce      = mem_ce_q;
    assign bus.mem_rden    = mem_rden_q;
    assign bus.mem_wren    = mem_wren_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wr_data = mem_wr_data_q;
    assign bus.busy        = busy_q;
    assign bus.grant_id    = grant_id_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level schedule model of the arbiter.
module tb_mem_arbiter;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_if bus();
    mem_arbiter #(.TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic       mem_enable = 1'b1;
    logic       init_mem   = 1'b0;
    logic       seen       = 1'b0;

    // Memory responder: mem_ready one cycle after strobes are first seen, junk read data otherwise.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
            bus.mem_ready <= 1'b0;
            seen          <= 1'b0;
        end else if (!rst_n || !bus.mem_ce) begin
            bus.mem_ready   <= 1'b0;
            bus.mem_rd_data <= 8'($urandom);
            seen            <= 1'b0;
        end else if (!seen && mem_enable) begin
            seen          <= 1'b1;
            bus.mem_ready <= 1'b1;
            if (bus.mem_wren) mem[bus.mem_addr] <= bus.mem_wr_data;
            bus.mem_rd_data <= bus.mem_rden ? mem[bus.mem_addr] : 8'($urandom);
        end else begin
            bus.mem_ready   <= 1'b0;
            bus.mem_rd_data <= 8'($urandom);
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = 8'h00; bus.wdata0 = 8'h00;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 8'h00; bus.wdata1 = 8'h00;
    endtask

    task automatic drive_req(input int i, input logic r, input logic w,
                             input logic [7:0] a, input logic [7:0] d);
        if (i == 0) begin
            bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    task automatic init_memories();
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i);
        init_mem = 1'b1;
        @(posedge clk);
        @(negedge clk);
        init_mem = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({bus.ack0, bus.ack1, bus.err0, bus.err1} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_acks: got %b expected 0000", {bus.ack0, bus.ack1, bus.err0, bus.err1});
        end
        n_checks++;
        if ({bus.rdata0, bus.rdata1} !== 16'h0000) begin
            n_fail++; $display("FAIL reset_rdata: got %h expected 0000", {bus.rdata0, bus.rdata1});
        end
        n_checks++;
        if ({bus.mem_ce, bus.mem_rden, bus.mem_wren, bus.busy, bus.grant_id} !== 5'b00000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {bus.mem_ce, bus.mem_rden, bus.mem_wren, bus.busy, bus.grant_id});
        end
        n_checks++;
        if ({bus.mem_addr, bus.mem_wr_data} !== 16'h0000) begin
            n_fail++; $display("FAIL reset_membus: got %h expected 0000", {bus.mem_addr, bus.mem_wr_data});
        end
    endtask

    task automatic test_read();
        apply_reset();
        drive_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
        for (int k = 1; k <= 3; k++) begin
            step();
            if (k < 3) begin
                n_checks++;
                if ({bus.mem_ce, bus.mem_rden, bus.mem_wren, bus.ack0, bus.mem_addr} !== {4'b1100, 8'h10}) begin
                    n_fail++; $display("FAIL read_strobes k=%0d: got %b/%h expected 1100/10", k,
                                       {bus.mem_ce, bus.mem_rden, bus.mem_wren, bus.ack0}, bus.mem_addr);
                end
            end else begin
                n_checks++;
                if ({bus.ack0, bus.err0, bus.rdata0, bus.ack1, bus.mem_ce} !== {2'b10, 8'h10, 2'b00}) begin
                    n_fail++; $display("FAIL read_done: got ack0=%b err0=%b rdata0=%h ack1=%b ce=%b expected 1 0 10 0 0",
                                       bus.ack0, bus.err0, bus.rdata0, bus.ack1, bus.mem_ce);
                end
                drive_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
            end
        end
        step();
        n_checks++;
        if ({bus.ack0, bus.busy, bus.mem_ce} !== 3'b000) begin
            n_fail++; $display("FAIL read_after: got %b expected 000", {bus.ack0, bus.busy, bus.mem_ce});
        end
    endtask

    task automatic test_write_read();
        apply_reset();
        drive_req(1, 1'b1, 1'b1, 8'h20, 8'hA5);
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k <= 2) begin
                n_checks++;
                if ({bus.mem_ce, bus.mem_rden, bus.mem_wren, bus.mem_addr, bus.mem_wr_data} !== {3'b101, 8'h20, 8'hA5}) begin
                    n_fail++; $display("FAIL wr_strobes k=%0d: got %b %h %h expected 101 20 a5", k,
                                       {bus.mem_ce, bus.mem_rden, bus.mem_wren}, bus.mem_addr, bus.mem_wr_data);
                end
            end else if (k == 3) begin
                n_checks++;
                if ({bus.ack1, bus.err1, bus.rdata1, bus.ack0} !== {2'b10, 8'h00, 1'b0}) begin
                    n_fail++; $display("FAIL wr_done: got ack1=%b err1=%b rdata1=%h ack0=%b expected 1 0 00 0",
                                       bus.ack1, bus.err1, bus.rdata1, bus.ack0);
                end
                bus.we1 = 1'b0;
            end else if (k == 4) begin
                n_checks++;
                if ({bus.mem_ce, bus.ack1} !== 2'b00) begin
                    n_fail++; $display("FAIL wr_gap: got ce=%b ack1=%b expected 0 0", bus.mem_ce, bus.ack1);
                end
            end else if (k == 5) begin
                n_checks++;
                if ({bus.mem_ce, bus.mem_rden, bus.grant_id, bus.busy} !== 4'b1111) begin
                    n_fail++; $display("FAIL rd2_grant: got %b expected 1111", {bus.mem_ce, bus.mem_rden, bus.grant_id, bus.busy});
                end
            end else if (k == 7) begin
                n_checks++;
                if ({bus.ack1, bus.err1, bus.rdata1} !== {2'b10, 8'hA5}) begin
                    n_fail++; $display("FAIL rd2_done: got ack1=%b err1=%b rdata1=%h expected 1 0 a5", bus.ack1, bus.err1, bus.rdata1);
                end
                drive_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
            end
        end
        step();
    endtask

    task automatic test_contention();
        logic e0, e1;
        apply_reset();
        drive_req(0, 1'b1, 1'b0, 8'h30, 8'h00);
        drive_req(1, 1'b1, 1'b0, 8'h31, 8'h00);
        for (int k = 1; k <= 16; k++) begin
            step();
            e0 = (k % 4 == 3) && (((k - 3) / 4) % 2 == 0);
            e1 = (k % 4 == 3) && (((k - 3) / 4) % 2 == 1);
            n_checks++;
            if ({bus.ack0, bus.ack1, bus.rdata0, bus.rdata1} !== {e0, e1, (e0 ? 8'h30 : 8'h00), (e1 ? 8'h31 : 8'h00)}) begin
                n_fail++; $display("FAIL contention_ack k=%0d: got %b%b %h %h expected %b%b", k,
                                   bus.ack0, bus.ack1, bus.rdata0, bus.rdata1, e0, e1);
            end
            if (k % 4 == 1) begin
                n_checks++;
                if (bus.grant_id !== 1'(((k - 1) / 4) % 2)) begin
                    n_fail++; $display("FAIL contention_grant k=%0d: got %b expected %0d", k, bus.grant_id, ((k - 1) / 4) % 2);
                end
            end
        end
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_timeout();
        apply_reset();
        mem_enable = 1'b0;
        drive_req(0, 1'b1, 1'b0, 8'h40, 8'h00);
        for (int k = 1; k <= TO + 1; k++) begin
            step();
            if (k <= TO) begin
                n_checks++;
                if ({bus.mem_ce, bus.mem_rden, bus.ack0, bus.err0, bus.busy} !== 5'b11001) begin
                    n_fail++; $display("FAIL timeout_wait k=%0d: got %b expected 11001", k,
                                       {bus.mem_ce, bus.mem_rden, bus.ack0, bus.err0, bus.busy});
                end
            end else begin
                n_checks++;
                if ({bus.ack0, bus.err0, bus.rdata0, bus.mem_ce, bus.ack1, bus.err1} !== {2'b11, 8'h00, 3'b000}) begin
                    n_fail++; $display("FAIL timeout_done: got ack0=%b err0=%b rdata0=%h ce=%b ack1=%b err1=%b expected 1 1 00 0 0 0",
                                       bus.ack0, bus.err0, bus.rdata0, bus.mem_ce, bus.ack1, bus.err1);
                end
                drive_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
            end
        end
        step();
        n_checks++;
        if ({bus.ack0, bus.err0} !== 2'b00) begin
            n_fail++; $display("FAIL timeout_pulse: got %b expected 00", {bus.ack0, bus.err0});
        end
        mem_enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
        step();
        step();
        rst_n = 1'b0;
        step();
        n_checks++;
        if ({bus.ack0, bus.ack1, bus.err0, bus.err1, bus.mem_ce, bus.mem_rden, bus.busy, bus.grant_id, bus.rdata0, bus.mem_addr}
            !== {8'h00, 8'h00, 8'h00}) begin
            n_fail++; $display("FAIL midreset_clear: got acks/ctrl=%b rdata0=%h mem_addr=%h expected all 0",
                               {bus.ack0, bus.ack1, bus.err0, bus.err1, bus.mem_ce, bus.mem_rden, bus.busy, bus.grant_id},
                               bus.rdata0, bus.mem_addr);
        end
        rst_n = 1'b1;
        drive_req(0, 1'b1, 1'b0, 8'h11, 8'h00);
        for (int k = 1; k <= 3; k++) begin
            step();
            n_checks++;
            if ({bus.ack0, bus.rdata0} !== ((k == 3) ? {1'b1, 8'h11} : 9'h000)) begin
                n_fail++; $display("FAIL midreset_after k=%0d: got ack0=%b rdata0=%h", k, bus.ack0, bus.rdata0);
            end
        end
        drive_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        step();
    endtask

    task automatic test_churn();
        apply_reset();
        drive_req(0, 1'b1, 1'b0, 8'h05, 8'h00);
        for (int k = 1; k <= 3; k++) begin
            step();
            if (k < 3) begin
                n_checks++;
                if ({bus.mem_addr, bus.mem_rden, bus.mem_wren} !== {8'h05, 2'b10}) begin
                    n_fail++; $display("FAIL churn_addr k=%0d: got %h %b%b expected 05 10", k, bus.mem_addr, bus.mem_rden, bus.mem_wren);
                end
                drive_req(0, 1'b1, 1'b1, (k == 1) ? 8'hF0 : 8'h0F, 8'h77);
            end else begin
                n_checks++;
                if ({bus.ack0, bus.rdata0} !== {1'b1, 8'h05}) begin
                    n_fail++; $display("FAIL churn_done: got ack0=%b rdata0=%h expected 1 05", bus.ack0, bus.rdata0);
                end
                drive_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
            end
        end
        step();
    endtask

    task automatic test_random();
        int         last_g  = -100;
        int         free_at = 0;
        logic       rr_last = 1'b1;
        logic       g_id = 1'b0, g_we = 1'b0;
        logic [7:0] g_addr = 8'h00, g_wdata = 8'h00, g_rdata = 8'h00;
        logic       in_acc, ackp, bsy, ea0, ea1, cur, owner;
        init_memories();
        apply_reset();
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk);
            // Transaction view: a grant may happen once the previous one is 4 edges old.
            if (k >= free_at && (bus.req0 || bus.req1)) begin
                g_id    = (bus.req0 && bus.req1) ? ~rr_last : bus.req1;
                rr_last = g_id;
                g_we    = g_id ? bus.we1 : bus.we0;
                g_addr  = g_id ? bus.addr1 : bus.addr0;
                g_wdata = g_id ? bus.wdata1 : bus.wdata0;
                g_rdata = g_we ? 8'h00 : ref_mem[g_addr];
                if (g_we) ref_mem[g_addr] = g_wdata;
                last_g  = k;
                free_at = k + 4;
            end
            @(negedge clk);
            in_acc = (k == last_g) || (k == last_g + 1);
            ackp   = (k == last_g + 2);
            bsy    = (k >= last_g) && (k <= last_g + 2);
            ea0    = ackp && !g_id;
            ea1    = ackp && g_id;
            n_checks++;
            if ({bus.ack0, bus.ack1, bus.err0, bus.err1} !== {ea0, ea1, 2'b00}) begin
                n_fail++; $display("FAIL rand_ack k=%0d: got %b expected %b%b00", k, {bus.ack0, bus.ack1, bus.err0, bus.err1}, ea0, ea1);
            end
            n_checks++;
            if ({bus.rdata0, bus.rdata1} !== {(ea0 ? g_rdata : 8'h00), (ea1 ? g_rdata : 8'h00)}) begin
                n_fail++; $display("FAIL rand_rdata k=%0d: got %h %h expected %h for id %b", k, bus.rdata0, bus.rdata1, g_rdata, g_id);
            end
            n_checks++;
            if ({bus.mem_ce, bus.mem_rden, bus.mem_wren, bus.busy} !== {in_acc, in_acc && !g_we, in_acc && g_we, bsy}) begin
                n_fail++; $display("FAIL rand_ctrl k=%0d: got %b expected %b%b%b%b", k,
                                   {bus.mem_ce, bus.mem_rden, bus.mem_wren, bus.busy}, in_acc, in_acc && !g_we, in_acc && g_we, bsy);
            end
            if (in_acc) begin
                n_checks++;
                if ({bus.mem_addr, bus.mem_wr_data, bus.grant_id} !== {g_addr, g_wdata, g_id}) begin
                    n_fail++; $display("FAIL rand_bus k=%0d: got %h %h %b expected %h %h %b", k,
                                       bus.mem_addr, bus.mem_wr_data, bus.grant_id, g_addr, g_wdata, g_id);
                end
            end
            for (int i = 0; i < 2; i++) begin
                cur   = (i == 0) ? bus.req0 : bus.req1;
                owner = in_acc && (g_id == i[0]);
                if (ackp && (g_id == i[0])) begin
                    drive_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom));
                end else if (owner) begin
                    if ($urandom_range(0, 2) == 0)
                        drive_req(i, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom));
                end else if (cur) begin
                    if ($urandom_range(0, 15) == 0) drive_req(i, 1'b0, 1'b0, 8'h00, 8'h00);
                end else if ($urandom_range(0, 2) == 0) begin
                    drive_req(i, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom));
                end
            end
        end
        idle_inputs();
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        init_memories();
        test_reset();
        test_read();
        test_write_read();
        test_contention();
        test_timeout();
        test_reset_mid();
        test_churn();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
